// File: rtl/nios2_system_bus_sequencer.sv
// nios2_system_bus_sequencer: Avalon-MM slave (address/chipselect/write_n/writedata -> readdata, irq) running one setup/strobe/hold word transfer on the external bus (bus_addr/bus_wdata/bus_oe/bus_rd_n/bus_wr_n, bus_wait/bus_rdata)
module nios2_system_bus_sequencer #(
  parameter int ADDR_W     = 11,
  parameter int DATA_W     = 8,
  parameter int SETUP_CYC  = 2,
  parameter int STROBE_CYC = 4,
  parameter int HOLD_CYC   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              irq,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic              bus_oe,
  output logic              bus_rd_n,
  output logic              bus_wr_n,
  input  logic              bus_wait,
  input  logic [DATA_W-1:0] bus_rdata
);
  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;
  state_t            state;
  logic [15:0]       cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;
  logic              done, overrun, irq_en, dir;
  logic              we, busy, start, unused_wd;
  assign we        = chipselect & ~write_n;
  assign busy      = state != IDLE;
  assign start     = we && address == 2'd2 && writedata[0];
  assign irq       = done & irq_en;
  assign unused_wd = ^writedata[31:ADDR_W];
  always_comb
    readdata = address == 2'd0 ? 32'(addr_q) :
               address == 2'd1 ? 32'(wdata_q) :
               address == 2'd2 ? {27'd0, dir, overrun, irq_en, done, busy} :
                                 32'(rdata_q);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      done      <= 1'b0;
      overrun   <= 1'b0;
      irq_en    <= 1'b0;
      dir       <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_oe    <= 1'b0;
      bus_rd_n  <= 1'b1;
      bus_wr_n  <= 1'b1;
    end else begin
      if (we && address == 2'd0) addr_q <= writedata[ADDR_W-1:0];
      if (we && address == 2'd1) wdata_q <= writedata[DATA_W-1:0];
      if (we && address == 2'd2) begin
        irq_en  <= writedata[2];
        overrun <= (overrun & ~writedata[3]) | (writedata[0] & busy);
      end
      if (we && address == 2'd3) done <= 1'b0;
      // completion is assigned after the done-clear so a finishing transfer wins
      case (state)
        IDLE: if (start) begin
          state     <= SETUP;
          cnt       <= 16'(SETUP_CYC - 1);
          bus_addr  <= addr_q;
          bus_wdata <= wdata_q;
          dir       <= writedata[1];
          bus_oe    <= ~writedata[1];
          done      <= 1'b0;
        end
        SETUP: if (cnt == 0) begin
          state    <= STROBE;
          cnt      <= 16'(STROBE_CYC - 1);
          bus_rd_n <= ~dir;
          bus_wr_n <= dir;
        end else cnt <= cnt - 1'b1;
        STROBE: if (cnt != 0) cnt <= cnt - 1'b1;
        else if (!bus_wait) begin
          state    <= HOLD;
          cnt      <= 16'(HOLD_CYC - 1);
          bus_rd_n <= 1'b1;
          bus_wr_n <= 1'b1;
          if (dir) rdata_q <= bus_rdata;
        end
        HOLD: if (cnt == 0) begin
          state  <= IDLE;
          done   <= 1'b1;
          bus_oe <= 1'b0;
        end else cnt <= cnt - 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nios2_system_bus_sequencer.sv
// tb_nios2_system_bus_sequencer: random and directed checks of the bus sequencer against a phase-count model
module tb_nios2_system_bus_sequencer;
  localparam int S = 2, T = 4, H = 1;
  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0, write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        irq, bus_oe, bus_rd_n, bus_wr_n;
  logic        bus_wait = 1'b0;
  logic [10:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic [7:0]  bus_rdata = '0;
  int tests = 0, fails = 0;
  nios2_system_bus_sequencer dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata), .irq(irq),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_oe(bus_oe),
    .bus_rd_n(bus_rd_n), .bus_wr_n(bus_wr_n), .bus_wait(bus_wait), .bus_rdata(bus_rdata)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask
  logic [10:0] m_addr = '0, m_baddr = '0;
  logic [7:0]  m_wdata = '0, m_bwdata = '0, m_rdata = '0;
  bit          m_done = 0, m_ovr = 0, m_irqen = 0, m_dir = 0, m_act = 0, m_was = 0;
  int          k = 0, len = T;
  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      m_addr = '0; m_baddr = '0; m_wdata = '0; m_bwdata = '0; m_rdata = '0;
      m_done = 0; m_ovr = 0; m_irqen = 0; m_dir = 0; m_act = 0; k = 0; len = T;
    end else begin
      m_was = m_act;
      if (chipselect && !write_n)
        case (address)
          2'd0: m_addr = writedata[10:0];
          2'd1: m_wdata = writedata[7:0];
          2'd2: begin
            m_irqen = writedata[2];
            if (writedata[3]) m_ovr = 0;
            if (writedata[0]) begin
              if (m_was) m_ovr = 1;
              else begin
                m_act = 1; k = 0; len = T;
                m_baddr = m_addr; m_bwdata = m_wdata; m_dir = writedata[1]; m_done = 0;
              end
            end
          end
          default: m_done = 0;
        endcase
      if (m_was) begin
        if (k == S + len - 1 && k - S >= T - 1 && bus_wait) len++;
        k++;
        if (k == S + len && m_dir) m_rdata = bus_rdata;
        if (k == S + len + H) begin m_act = 0; m_done = 1; end
      end
    end
  end
  function automatic logic [31:0] exp_rd();
    case (address)
      2'd0: return 32'(m_addr);
      2'd1: return 32'(m_wdata);
      2'd2: return {27'd0, m_dir, m_ovr, m_irqen, m_done, m_act};
      default: return 32'(m_rdata);
    endcase
  endfunction
  initial forever begin
    @(posedge clk);
    #1;
    begin
      bit strb;
      strb = m_act && k >= S && k < S + len;
      chk("cycle_outputs",
          64'({readdata, irq, bus_addr, bus_wdata, bus_oe, bus_rd_n, bus_wr_n}),
          64'({exp_rd(), m_done & m_irqen, m_baddr, m_bwdata, m_act & ~m_dir,
               ~(strb & m_dir), ~(strb & ~m_dir)}));
    end
  end
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask
  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    address = a;
    #1;
    v = readdata;
  endtask
  task automatic wait_idle();
    logic [31:0] v;
    int n;
    n = 0;
    rd(2, v);
    while (v[0] && n < 60) begin
      @(negedge clk);
      rd(2, v);
      n++;
    end
    chk("idle_timeout", 64'(v[0]), 64'(0));
  endtask
  task automatic track(input bit rdir, input int n, input int w0, input int w1, input logic [10:0] ea,
                       output int first, output int cnt, output int done_at, output int bad);
    first = -1; cnt = 0; done_at = -1; bad = 0;
    for (int i = 0; i < n; i++) begin
      logic s;
      logic [31:0] v;
      s = rdir ? bus_rd_n : bus_wr_n;
      if (!s) begin
        if (first < 0) first = i;
        cnt++;
        if (bus_oe !== !rdir) bad++;
      end
      if (bus_addr !== ea) bad++;
      rd(2, v);
      if (v[1] && done_at < 0) done_at = i;
      bus_wait = i >= w0 && i <= w1;
      @(negedge clk);
    end
    bus_wait = 1'b0;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [31:0] v;
    int first, cnt, done_at, bad, n;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), v);
      chk("reset_reg", v, 64'(0));
    end
    chk("reset_bus", 64'({irq, bus_oe, bus_rd_n, bus_wr_n, bus_addr, bus_wdata}), 64'({4'b0011, 19'd0}));
    wr(0, 32'h2A5); wr(1, 32'h3C); wr(2, 32'h1);
    track(0, 12, 99, 0, 11'h2A5, first, cnt, done_at, bad);
    chk("wr_first", 64'(first), 64'(2));
    chk("wr_len", 64'(cnt), 64'(4));
    chk("wr_done_at", 64'(done_at), 64'(7));
    chk("wr_addr_oe", 64'(bad), 64'(0));
    chk("wr_wdata", 64'(bus_wdata), 64'(8'h3C));
    rd(2, v); chk("wr_status", v, 64'(32'h02));
    bus_rdata = 8'h96;
    wr(0, 32'h7FF); wr(2, 32'h3);
    track(1, 14, 5, 7, 11'h7FF, first, cnt, done_at, bad);
    chk("rd_first", 64'(first), 64'(2));
    chk("rd_len", 64'(cnt), 64'(7));
    chk("rd_done_at", 64'(done_at), 64'(10));
    chk("rd_addr_oe", 64'(bad), 64'(0));
    rd(3, v); chk("rd_rdata", v, 64'(32'h96));
    rd(2, v); chk("rd_status", v, 64'(32'h12));
    wr(2, 32'h1); wr(2, 32'h1);
    rd(2, v); chk("ovr_busy", v, 64'(32'h09));
    wait_idle();
    repeat (3) @(negedge clk);
    rd(2, v); chk("ovr_single", v, 64'(32'h0A));
    wr(2, 32'h8);
    rd(2, v); chk("ovr_clear", v, 64'(32'h02));
    wr(0, 32'hFFFF); rd(0, v); chk("addr_mask", v, 64'(32'h7FF));
    wr(1, 32'h1FF);  rd(1, v); chk("wdata_mask", v, 64'(32'hFF));
    wr(0, 32'h123); wr(2, 32'h1); wr(0, 32'h055);
    chk("busy_addr_latched", 64'(bus_addr), 64'(11'h123));
    rd(0, v); chk("busy_addr_reg", v, 64'(32'h055));
    wait_idle();
    chk("idle_addr_hold", 64'(bus_addr), 64'(11'h123));
    wr(2, 32'h5);
    wait_idle();
    chk("irq_set", 64'(irq), 64'(1));
    wr(3, 32'h0);
    chk("irq_clear", 64'(irq), 64'(0));
    rd(2, v); chk("irq_status", v, 64'(32'h04));
    wr(1, 32'hA5); wr(2, 32'h1);
    n = 0;
    while (bus_wr_n && n < 20) begin @(negedge clk); n++; end
    chk("rst_strobe_seen", 64'(bus_wr_n), 64'(0));
    #2 reset = 1'b1;
    #1 chk("rst_async", 64'({bus_rd_n, bus_wr_n, bus_oe}), 64'(3'b110));
    @(negedge clk);
    reset = 1'b0;
    rd(2, v); chk("rst_status", v, 64'(0));
    rd(0, v); chk("rst_addr", v, 64'(0));
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      chipselect = ($urandom % 4) == 0;
      write_n    = ($urandom % 4) == 0;
      address    = 2'($urandom);
      writedata  = $urandom;
      bus_wait   = ($urandom % 3) == 0;
      bus_rdata  = 8'($urandom);
    end
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; bus_wait = 1'b0;
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/nios2_system_bus_sequencer.md
# nios2_system_bus_sequencer

Avalon-MM slave that sequences single-word transactions on the external parallel bus whose 11-bit address the Nios II system drives. Software loads address, write data and a command; the block then generates setup/strobe/hold timing on the external bus, captures read data, and reports completion through a sticky done flag and an optional interrupt. It sits between the Nios II data master and the external game-board peripheral bus, replacing bit-banged PIO sequencing.

## Interface
- ADDR_W, 11, external address width
- DATA_W, 8, external data width
- SETUP_CYC, 2, address-valid cycles before strobe (≥1)
- STROBE_CYC, 4, minimum strobe-low cycles (≥1)
- HOLD_CYC, 1, address/data hold cycles after strobe (≥1)

- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- address  in  2  Avalon word address
- chipselect  in  1  Avalon select
- write_n  in  1  Avalon write, active low
- writedata  in  32  Avalon write data
- readdata  out  32  Avalon read data, combinational on address, zero-extended
- irq  out  1  done & irq_en
- bus_addr  out  ADDR_W  external address
- bus_wdata  out  DATA_W  external write data
- bus_oe  out  1  drive bus_wdata onto external data lines
- bus_rd_n  out  1  read strobe, active low
- bus_wr_n  out  1  write strobe, active low
- bus_wait  in  1  peripheral extends strobe while high
- bus_rdata  in  DATA_W  external read data

## Operation
- Registers (write = chipselect & ~write_n):
  - 0 ADDR: RW, bits ADDR_W-1:0.
  - 1 WDATA: RW, bits DATA_W-1:0.
  - 2 CTRL/STATUS: write bit0 start, bit1 dir (1 = read), bit2 irq_en, bit3 writing 1 clears overrun. Read: bit0 busy, bit1 done, bit2 irq_en, bit3 overrun, bit4 dir of last transaction.
  - 3 RDATA: RO captured read data; any write to address 3 clears done.
- Start accepted only in IDLE: latch ADDR→bus_addr, WDATA→bus_wdata, dir; clear done; enter SETUP. irq_en updates on every CTRL write.
- Start while busy: ignored, overrun set (sticky). ADDR/WDATA writes while busy update the registers only; the running transaction uses latched copies.
- FSM: IDLE → SETUP (SETUP_CYC cycles) → STROBE (≥STROBE_CYC cycles, then remains while bus_wait=1) → HOLD (HOLD_CYC cycles) → IDLE, done←1.
- bus_rd_n (dir=1) or bus_wr_n (dir=0) low exactly during STROBE; bus_oe=1 in SETUP, STROBE, HOLD for writes only.
- Read data: bus_rdata sampled into RDATA on the edge leaving STROBE.
- bus_addr holds its last value in IDLE.
- All bus outputs registered; no combinational paths from inputs to strobes.
- Reset values: state IDLE, ADDR 0, WDATA 0, RDATA 0, done/overrun/irq_en/dir 0, bus_addr 0, bus_wdata 0, bus_oe 0, bus_rd_n 1, bus_wr_n 1, irq 0, readdata 0.

## Timing
- Start accepted at edge E0: busy reads 1 from the cycle after E0.
- Defaults, bus_wait=0: bus_addr valid after E0; strobe low from E0+2 to E0+6 (4 cycles); HOLD E0+6..E0+7; done=1 and busy=0 after E0+7. Total = SETUP_CYC+STROBE_CYC+HOLD_CYC cycles.
- bus_wait is sampled each STROBE cycle once the minimum count has expired. Each high sample adds one strobe cycle.
- Simultaneous CTRL start and RDATA write in the same cycle is impossible (single port); clearing done in IDLE has no effect on the FSM.
- Asynchronous reset mid-transaction: strobes deassert and bus_oe drops immediately; no done is produced.
- irq is registered-equivalent: it follows done & irq_en with no extra cycle of latency.

## Test plan
- Write: ADDR=0x2A5, WDATA=0x3C, CTRL=0x1 → bus_wr_n low exactly 4 cycles starting 2 cycles after the start edge; bus_addr=0x2A5 and bus_oe=1 throughout; done=1 after 7 cycles.
- Read with wait: ADDR=0x7FF, CTRL=0x3, bus_wait high for 3 cycles after strobe cycle 4, bus_rdata=0x96 → strobe 7 cycles; RDATA=0x96; STATUS=0x12.
- Overrun: CTRL=0x1 issued twice 1 cycle apart → single transaction; overrun=1; writing CTRL bit3 clears it.
- Register readback: ADDR=0xFFFF reads 0x7FF; WDATA=0x1FF reads 0xFF; ADDR write during busy does not change bus_addr.
- IRQ: CTRL=0x5 → irq=1 at done; a write to address 3 drops irq and done the next cycle.
- Reset asserted during STROBE → bus_rd_n/bus_wr_n=1 and bus_oe=0 immediately; after release, STATUS=0.
